// File: rtl/ram_arb_pkg.sv
// Shared types for the two-requester RAM port arbiter: owner encoding,
// burst counter width and the per-requester request bundle.
`timescale 1ns/1ps
package ram_arb_pkg;

  localparam int ARB_DATA_W = 8;
  localparam int ARB_ADDR_W = 6;
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_A    = 2'd1,
    OWN_B    = 2'd2
  } owner_t;

  typedef struct packed {
    logic                  we;
    logic [ARB_ADDR_W-1:0] addr;
    logic [ARB_DATA_W-1:0] wdata;
  } req_bundle_t;

  function automatic owner_t other_side(input owner_t o);
    return (o == OWN_A) ? OWN_B : OWN_A;
  endfunction

endpackage

// File: rtl/ram_arb_rr_sel.sv
// Combinational grant selector: lone requester wins, otherwise the owner keeps
// the port until its burst budget is spent; with no owner the pointer decides.
`timescale 1ns/1ps
module ram_arb_rr_sel
  import ram_arb_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic             req_a_i,
  input  logic             req_b_i,
  input  owner_t           owner_i,
  input  logic [CNT_W-1:0] count_i,
  input  owner_t           ptr_i,
  output logic             gnt_a_o,
  output logic             gnt_b_o
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

  always_comb begin
    gnt_a_o = 1'b0;
    gnt_b_o = 1'b0;
    if (req_a_i && req_b_i) begin
      case (owner_i)
        OWN_A: begin
          if (count_i < MAX_CNT) gnt_a_o = 1'b1;
          else                   gnt_b_o = 1'b1;
        end
        OWN_B: begin
          if (count_i < MAX_CNT) gnt_b_o = 1'b1;
          else                   gnt_a_o = 1'b1;
        end
        default: begin
          if (ptr_i == OWN_B) gnt_b_o = 1'b1;
          else                gnt_a_o = 1'b1;
        end
      endcase
    end else begin
      gnt_a_o = req_a_i;
      gnt_b_o = req_b_i;
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one single-port registered-read RAM between requesters A and B with
// round-robin, burst-bounded arbitration and a one-cycle read return path.
`timescale 1ns/1ps
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int DATA_W    = ARB_DATA_W,
  parameter int ADDR_W    = ARB_ADDR_W,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_a,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] wdata_a,
  output logic              gnt_a,
  output logic              rvalid_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic              req_b,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] wdata_b,
  output logic              gnt_b,
  output logic              rvalid_b,
  output logic [DATA_W-1:0] rdata_b,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } port_req_t;

  owner_t           owner_q, owner_d;
  owner_t           ptr_q, ptr_d;
  owner_t           xfer_owner;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sel_a, sel_b;
  port_req_t        req_a_s, req_b_s, req_sel;

  ram_arb_rr_sel #(
    .MAX_BURST (MAX_BURST)
  ) u_sel (
    .req_a_i (req_a),
    .req_b_i (req_b),
    .owner_i (owner_q),
    .count_i (cnt_q),
    .ptr_i   (ptr_q),
    .gnt_a_o (sel_a),
    .gnt_b_o (sel_b)
  );

  // Grants are gated by reset so nothing reaches the RAM while rst_n is low.
  assign gnt_a = sel_a & rst_n;
  assign gnt_b = sel_b & rst_n;

  assign req_a_s   = {we_a, addr_a, wdata_a};
  assign req_b_s   = {we_b, addr_b, wdata_b};
  assign req_sel   = gnt_b ? req_b_s : req_a_s;
  assign mem_en    = gnt_a | gnt_b;
  assign mem_we    = mem_en & req_sel.we;
  assign mem_addr  = req_sel.addr;
  assign mem_wdata = req_sel.wdata;

  always_comb begin
    owner_d    = owner_q;
    cnt_d      = cnt_q;
    ptr_d      = ptr_q;
    xfer_owner = gnt_b ? OWN_B : OWN_A;
    if (mem_en) begin
      if (xfer_owner == owner_q) begin
        if (cnt_q < MAX_CNT) cnt_d = cnt_q + CNT_W'(1);
      end else begin
        owner_d = xfer_owner;
        cnt_d   = CNT_W'(1);
      end
      ptr_d = other_side(xfer_owner);
    end else begin
      owner_d = OWN_NONE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q <= OWN_NONE;
      cnt_q   <= '0;
      ptr_q   <= OWN_A;
    end else begin
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
    end
  end

  // Read return, one lane per requester (0 = A, 1 = B).
  logic [1:0]        rd_gnt;
  logic [1:0]        rvalid_vec;
  logic [DATA_W-1:0] rdata_vec [2];

  assign rd_gnt = {gnt_b & ~we_b, gnt_a & ~we_a};

  for (genvar gi = 0; gi < 2; gi++) begin : g_ret
    logic              rvalid_q;
    logic [DATA_W-1:0] hold_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rvalid_q <= 1'b0;
        hold_q   <= '0;
      end else begin
        rvalid_q <= rd_gnt[gi];
        if (rvalid_q) hold_q <= mem_rdata;
      end
    end

    // The RAM output is live only in the return cycle, so it is passed
    // through then and the captured copy is presented afterwards.
    assign rvalid_vec[gi] = rvalid_q;
    assign rdata_vec[gi]  = rvalid_q ? mem_rdata : hold_q;
  end

  assign rvalid_a = rvalid_vec[0];
  assign rvalid_b = rvalid_vec[1];
  assign rdata_a  = rdata_vec[0];
  assign rdata_b  = rdata_vec[1];

endmodule
